nitta_to_spi_serializer: RTL and testbench
==========================================

// Module: nitta_to_spi_serializer
// PURPOSE
//  Transmit-side counterpart of the SPI receive splitter. Accepts DATA_WIDTH words from NITTA
//  into a small FIFO and slices each word into SUBFRAME_NUMBER = DATA_WIDTH/SPI_DATA_WIDTH
//  subframes for the SPI slave transmitter, advancing one subframe per spi_ready request.
//  Sits between the NITTA output side and the SPI slave shift logic.
// PARAMETERS
//  DATA_WIDTH      32     NITTA word width; must be an integer multiple of SPI_DATA_WIDTH
//  ATTR_WIDTH      4      NITTA attribute width; carried for interface uniformity, unused
//  SPI_DATA_WIDTH  8      subframe width presented to the SPI transmitter
//  FIFO_DEPTH      2      word FIFO depth; power of two, >= 2
//  IDLE_SUBFRAME   all 1s value driven on to_spi when no word is active
// PORTS
//  clk              in   1               system clock, all logic on posedge
//  rst              in   1               asynchronous reset, active high
//  from_nitta_valid in   1               push strobe; word sampled on the edge where it is high
//  from_nitta       in   DATA_WIDTH      word to transmit
//  serializer_ready out  1               high when FIFO not full (a push will be accepted)
//  spi_ready        in   1               SPI transmitter request for next subframe (level, see below)
//  to_spi           out  SPI_DATA_WIDTH  current subframe, stable between requests
//  frame_done       out  1               one-cycle pulse: last subframe of a word consumed
//  underrun         out  1               one-cycle pulse: request arrived while idle
//  overflow         out  1               one-cycle pulse: push dropped because FIFO full
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, state IDLE, subframe counter 0, armed=0,
//   to_spi=IDLE_SUBFRAME, serializer_ready=1, frame_done=underrun=overflow=0.
//  Request detection: armed<=1 on any edge with spi_ready=0; a request is counted on an edge
//   with spi_ready=1 & armed=1, which clears armed. spi_ready held high counts exactly once;
//   spi_ready high straight out of reset counts nothing until it has been low once.
//  FIFO: push when from_nitta_valid & !full; push when full is dropped, overflow pulses next cycle.
//   Push and pop on the same edge are both honoured, including when full (pop frees the slot).
//   serializer_ready is registered and reflects FIFO occupancy after the current edge.
//  FSM IDLE: on edge with FIFO non-empty -> pop head into shift register, counter=0, go SHIFT;
//   to_spi shows subframe 0 from that edge. Push at edge E into empty FIFO -> subframe 0 at E+1.
//   A request in IDLE -> underrun pulse, to_spi stays IDLE_SUBFRAME, state unchanged.
//  FSM SHIFT: to_spi = most-significant SPI_DATA_WIDTH bits of shift register.
//   Request with counter < SUBFRAME_NUMBER-1: shift left by SPI_DATA_WIDTH, counter+1.
//   Request with counter = SUBFRAME_NUMBER-1: frame_done pulse; if FIFO non-empty pop next word
//   on the same edge (back-to-back, no idle subframe), counter=0; else to_spi=IDLE_SUBFRAME, go IDLE.
//  Counter width $clog2(SUBFRAME_NUMBER)+1; never exceeds SUBFRAME_NUMBER-1; no wrap.
//  SUBFRAME_NUMBER=1 is legal: every request completes a frame.
//  All status pulses are registered, exactly one cycle, never asserted together with reset.
// CONFIGURATION
//  NITTA_SPI_LSB_FIRST_EN defined: subframes emitted least-significant first (shift right,
//   to_spi = low bits). Undefined (default): most-significant first, matching the receive
//   splitter, which assembles words MSB-first. Handshake and timing identical in both modes.
// TESTING (DATA_WIDTH=32, SPI_DATA_WIDTH=8, FIFO_DEPTH=2, IDLE_SUBFRAME=8'hFF)
//  1. push 32'hA1B2C3D4, 4 spi_ready low/high pulses -> to_spi A1,B2,C3,D4; frame_done after 4th; then FF.
//  2. push 3 words, no requests -> first loaded, 2 in FIFO, serializer_ready=0; 4th push -> overflow pulse, word lost.
//  3. push 11223344 and 55667788, 8 requests -> 11,22,33,44,55,66,77,88 gap-free; two frame_done pulses.
//  4. no data, one request -> underrun pulse, to_spi stays FF; spi_ready held high 10 cycles -> counts once.
//  5. rst mid-frame after 2 subframes, spi_ready high -> to_spi=FF, ready=1, FIFO empty; no count until spi_ready low.
//  6. NITTA_SPI_LSB_FIRST_EN, push A1B2C3D4, 4 requests -> D4,C3,B2,A1.

Source files
------------

// File: rtl/nitta_to_spi_serializer_if.sv
// Bus between the NITTA output side, the serializer and the SPI slave transmitter.
// The master drives words and SPI requests; the slave (serializer) returns subframes and status.
interface nitta_to_spi_serializer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8
);
    logic                      from_nitta_valid;
    logic [DATA_WIDTH-1:0]     from_nitta;
    logic                      serializer_ready;
    logic                      spi_ready;
    logic [SPI_DATA_WIDTH-1:0] to_spi;
    logic                      frame_done;
    logic                      underrun;
    logic                      overflow;

    modport master (
        output from_nitta_valid, from_nitta, spi_ready,
        input  serializer_ready, to_spi, frame_done, underrun, overflow
    );

    modport slave (
        input  from_nitta_valid, from_nitta, spi_ready,
        output serializer_ready, to_spi, frame_done, underrun, overflow
    );
endinterface

// File: rtl/nitta_to_spi_serializer.sv
// Word FIFO plus subframe slicer feeding the SPI slave transmitter, one subframe per spi_ready request.
// Optional macro NITTA_SPI_LSB_FIRST_EN: emit subframes least-significant first (default MSB first).
module nitta_to_spi_serializer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ATTR_WIDTH     = 4,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 2,
    parameter logic [SPI_DATA_WIDTH-1:0] IDLE_SUBFRAME = {SPI_DATA_WIDTH{1'b1}}
) (
    input  logic clk,
    input  logic rst,
    nitta_to_spi_serializer_if.slave bus
);
    localparam int SUBFRAME_NUMBER = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int CNT_W           = $clog2(SUBFRAME_NUMBER) + 1;
    localparam int PTR_W           = $clog2(FIFO_DEPTH);
    localparam int OCC_W           = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SUBFRAME_NUMBER - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    generate
        if ((DATA_WIDTH % SPI_DATA_WIDTH) != 0 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ATTR_WIDTH < 1) begin : g_bad_params
            $error("nitta_to_spi_serializer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic [DATA_WIDTH-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      armed_q, armed_d;
    logic [SPI_DATA_WIDTH-1:0] to_spi_q, to_spi_d;
    logic                      ready_q, ready_d;
    logic                      frame_done_q, frame_done_d;
    logic                      underrun_q, underrun_d;
    logic                      overflow_q, overflow_d;
    logic                      request_s, push_s, pop_s, empty_s, full_s;
    logic [DATA_WIDTH-1:0]     shifted_s;
    logic [SPI_DATA_WIDTH-1:0] sub_s;

    assign empty_s   = (occ_q == {OCC_W{1'b0}});
    assign full_s    = (occ_q == FULL_OCC);
    // A request needs spi_ready to have been seen low since the last one was taken.
    assign request_s = bus.spi_ready & armed_q;
    assign armed_d   = ~bus.spi_ready;

`ifdef NITTA_SPI_LSB_FIRST_EN
    assign shifted_s = sh_q >> SPI_DATA_WIDTH;
    assign sub_s     = sh_d[SPI_DATA_WIDTH-1:0];
`else
    assign shifted_s = sh_q << SPI_DATA_WIDTH;
    assign sub_s     = sh_d[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
`endif

    // Serializer FSM, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        pop_s        = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                underrun_d = request_s;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (request_s && (cnt_q != LAST_CNT)) begin
                    sh_d  = shifted_s;
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end else if (request_s) begin
                    frame_done_d = 1'b1;
                    cnt_d        = {CNT_W{1'b0}};
                    if (!empty_s) begin
                        pop_s = 1'b1;
                        sh_d  = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        push_s     = bus.from_nitta_valid & (~full_s | pop_s);
        overflow_d = bus.from_nitta_valid & ~push_s;
        wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
        if (push_s && !pop_s) begin
            occ_d = occ_q + OCC_W'(1'b1);
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - OCC_W'(1'b1);
        end else begin
            occ_d = occ_q;
        end
        ready_d  = (occ_d != FULL_OCC);
        to_spi_d = (state_d == S_SHIFT) ? sub_s : IDLE_SUBFRAME;
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            state_q      <= S_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
            sh_q         <= {DATA_WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            armed_q      <= 1'b0;
            to_spi_q     <= IDLE_SUBFRAME;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= bus.from_nitta;
            end
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            to_spi_q     <= to_spi_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.to_spi           = to_spi_q;
    assign bus.serializer_ready = ready_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.underrun         = underrun_q;
    assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_nitta_to_spi_serializer.sv
// Scoreboard bench for nitta_to_spi_serializer: a queue-based word/subframe model predicts every
// cycle's outputs, a monitor compares them #1 after each clock edge; directed scenarios add spot checks.
module tb_nitta_to_spi_serializer;
    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int DEPTH = 2;
    localparam int NSUB  = DW / SW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    nitta_to_spi_serializer_if #(.DATA_WIDTH(DW), .SPI_DATA_WIDTH(SW)) bus ();

    nitta_to_spi_serializer #(
        .DATA_WIDTH(DW), .ATTR_WIDTH(4), .SPI_DATA_WIDTH(SW), .FIFO_DEPTH(DEPTH),
        .IDLE_SUBFRAME(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: words waiting, subframes of the word on the wire, last spi_ready level.
    logic [DW-1:0] m_fifo [$];
    logic [SW-1:0] m_sub  [$];
    bit            m_active;
    bit            m_armed;
    logic [11:0]   sb     [$];
    logic [11:0]   mon_exp, mon_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_sub.delete();
        m_active = 1'b0;
        m_armed  = 1'b0;
        sb.delete();
    endtask

    task automatic load(input logic [DW-1:0] w);
        m_sub.delete();
        for (int i = 0; i < NSUB; i++) begin
`ifdef NITTA_SPI_LSB_FIRST_EN
            m_sub.push_back(w[i*SW +: SW]);
`else
            m_sub.push_back(w[DW-1-i*SW -: SW]);
`endif
        end
        m_active = 1'b1;
    endtask

    // Expected {to_spi, serializer_ready, frame_done, underrun, overflow} after one clock edge.
    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit sr, output logic [11:0] e);
        bit req, fd, ur, ov, pop, acc, full_before;
        req         = sr && m_armed;
        m_armed     = !sr;
        full_before = (m_fifo.size() == DEPTH);
        fd = 1'b0; ur = 1'b0; pop = 1'b0;
        if (!m_active) begin
            ur = req;
            if (m_fifo.size() > 0) begin
                load(m_fifo.pop_front());
                pop = 1'b1;
            end
        end else if (req) begin
            if (m_sub.size() > 1) begin
                void'(m_sub.pop_front());
            end else begin
                fd = 1'b1;
                m_sub.delete();
                m_active = 1'b0;
                if (m_fifo.size() > 0) begin
                    load(m_fifo.pop_front());
                    pop = 1'b1;
                end
            end
        end
        acc = v && (!full_before || pop);
        if (acc) m_fifo.push_back(d);
        ov = v && !acc;
        e = {(m_active ? m_sub[0] : 8'hFF), (m_fifo.size() < DEPTH), fd, ur, ov};
    endtask

    // One clock: drive inputs, predict, then return 2 time units after the edge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit sr);
        logic [11:0] e;
        bus.from_nitta_valid = v;
        bus.from_nitta       = d;
        bus.spi_ready        = sr;
        model_edge(v, d, sr, e);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic request();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_act = {bus.to_spi, bus.serializer_ready, bus.frame_done, bus.underrun, bus.overflow};
            check("scoreboard", {20'h0, mon_act}, {20'h0, mon_exp});
        end
    end

    logic [SW-1:0] t1 [4];
    logic [SW-1:0] t3 [8];
    logic [SW-1:0] mid5;
    int            cnt;

    initial begin
`ifdef NITTA_SPI_LSB_FIRST_EN
        t1   = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        t3   = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        mid5 = 8'hB2;
`else
        t1   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        t3   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        mid5 = 8'hC3;
`endif
        bus.from_nitta_valid = 1'b0;
        bus.from_nitta       = 32'h0;
        bus.spi_ready        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", {bus.to_spi, bus.serializer_ready, bus.frame_done, bus.underrun, bus.overflow},
              {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        // 1: single word, four requests
        cycle(1'b1, 32'hA1B2C3D4, 1'b0);
        check("t1_not_yet", bus.to_spi, 8'hFF);
        cycle(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t1_sub", bus.to_spi, t1[i]);
            cycle(1'b0, 32'h0, 1'b1);
            if (i < 3) cycle(1'b0, 32'h0, 1'b0);
        end
        check("t1_done", {bus.frame_done, bus.to_spi}, {1'b1, 8'hFF});
        cycle(1'b0, 32'h0, 1'b0);
        check("t1_done_pulse", bus.frame_done, 1'b0);

        // 2: fill the FIFO and overflow it
        cycle(1'b1, 32'h01020304, 1'b0);
        cycle(1'b1, 32'h05060708, 1'b0);
        cycle(1'b1, 32'h090A0B0C, 1'b0);
        check("t2_full", bus.serializer_ready, 1'b0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0);
        check("t2_overflow", bus.overflow, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);
        check("t2_overflow_pulse", bus.overflow, 1'b0);
        repeat (12) request();
        check("t2_drained", {bus.to_spi, bus.serializer_ready}, {8'hFF, 1'b1});

        // 3: back-to-back words
        cycle(1'b1, 32'h11223344, 1'b0);
        cycle(1'b1, 32'h55667788, 1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            check("t3_sub", bus.to_spi, t3[i]);
            request();
            if (bus.frame_done) cnt++;
        end
        check("t3_frames", cnt, 2);
        check("t3_idle", bus.to_spi, 8'hFF);

        // 4: underrun, held request counts once
        request();
        check("t4_underrun", {bus.underrun, bus.to_spi}, {1'b1, 8'hFF});
        cnt = 0;
        repeat (10) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (bus.underrun) cnt++;
        end
        check("t4_held", cnt, 0);

        // 5: reset mid-frame with spi_ready high
        cycle(1'b1, 32'hA1B2C3D4, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        request();
        request();
        check("t5_mid", bus.to_spi, mid5);
        cycle(1'b1, 32'hCAFEF00D, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_reset", {bus.to_spi, bus.serializer_ready, bus.frame_done, bus.underrun, bus.overflow},
              {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        cnt = 0;
        repeat (3) begin
            cycle(1'b0, 32'h0, 1'b1);
            if (bus.underrun) cnt++;
        end
        check("t5_no_count", cnt, 0);
        check("t5_fifo_empty", bus.to_spi, 8'hFF);
        request();
        check("t5_counts_after_low", bus.underrun, 1'b1);

        // random traffic against the model
        repeat (3000) begin
            cycle(($urandom % 3) == 0, $urandom, ($urandom % 2) == 1);
        end
        cycle(1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
